// File: rtl/io_cmd_sequencer.sv
// rtl/io_cmd_sequencer.sv - command FIFO and issue FSM for the RTC/LED peripheral.
// Optional GET reply timeout and sticky err flag enabled by defining IOSEQ_TIMEOUT_EN.
module io_cmd_sequencer #(
   parameter int          DEPTH   = 4,
`ifdef IOSEQ_TIMEOUT_EN
   parameter int          TIMEOUT = 16,
`endif
   parameter logic [7:0]  OP_GET  = 8'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic [23:0] wdata,
   output logic        full,
   input  logic        rd,
   output logic [23:0] rdata,
   output logic        rvalid,
   output logic        start,
   output logic [23:0] cmd,
   input  logic        rdy_in,
   input  logic [23:0] resp_in,
   output logic        busy,
   output logic        err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

   state_t        state_q, state_d;
   logic [23:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic [23:0]   rdata_q, rdata_d;
   logic          rvalid_q, rvalid_d;
   logic          push, pop, capture;
   logic [23:0]   cap_data, head;

   assign head  = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign push  = wr && !full;
   assign busy  = (count_q != '0) || (state_q != ST_IDLE);
   assign start = (state_q == ST_ISSUE);
   assign cmd   = start ? head : 24'h0;
   assign rdata = rdata_q;
   assign rvalid = rvalid_q;

`ifdef IOSEQ_TIMEOUT_EN
   logic [7:0] wcnt_q, wcnt_d;
   logic       err_q, err_d;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      capture  = 1'b0;
      cap_data = resp_in;
`ifdef IOSEQ_TIMEOUT_EN
      wcnt_d   = wcnt_q;
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: if (count_q != '0) state_d = ST_ISSUE;
         ST_ISSUE: begin
            pop = 1'b1;
            if (head[23:16] != OP_GET) begin
               state_d = ST_GAP;
            end else if (rdy_in) begin
               capture = 1'b1;
               state_d = ST_GAP;
            end else begin
               state_d = ST_WAIT;
`ifdef IOSEQ_TIMEOUT_EN
               wcnt_d  = 8'd0;
`endif
            end
         end
         ST_WAIT: begin
            if (rdy_in) begin
               capture = 1'b1;
               state_d = ST_GAP;
            end
`ifdef IOSEQ_TIMEOUT_EN
            // A real reply in the final cycle takes priority over the timeout.
            else if (wcnt_q == 8'(TIMEOUT - 1)) begin
               capture  = 1'b1;
               cap_data = 24'hFF0000;
               err_d    = 1'b1;
               state_d  = ST_GAP;
            end else begin
               wcnt_d = wcnt_q + 8'd1;
            end
`endif
         end
         ST_GAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Capture beats a same-cycle rd so a fresh reply is never lost.
   always_comb begin
      rdata_d  = capture ? cap_data : rdata_q;
      rvalid_d = capture ? 1'b1 : (rd ? 1'b0 : rvalid_q);
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdata_q  <= 24'h0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

`ifdef IOSEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt_q <= 8'd0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         err_q  <= err_d;
      end
   end
`endif

endmodule
